// File: rtl/dpram_param.sv
// Single-clock true dual-port RAM with lane write masks, defined same-address
// collision behaviour, read-valid strobes and 1- or 2-cycle read latency.
module dpram_param #(
    parameter int WIDTH        = 16,
    parameter int DEPTH        = 2048,
    parameter int ADDR_WIDTH   = $clog2(DEPTH),
    parameter int MASK_GRAN    = 8,
    parameter int READ_LATENCY = 1,
    parameter int BYPASS       = 1,
    localparam int NLANES      = WIDTH / MASK_GRAN
) (
    input  logic                  clk,
    input  logic                  nreset,
    input  logic                  cen_a,
    input  logic                  rdwen_a,
    input  logic [ADDR_WIDTH-1:0] a_a,
    input  logic [WIDTH-1:0]      d_a,
    input  logic [NLANES-1:0]     bwen_a,
    input  logic                  cen_b,
    input  logic                  rdwen_b,
    input  logic [ADDR_WIDTH-1:0] a_b,
    input  logic [WIDTH-1:0]      d_b,
    input  logic [NLANES-1:0]     bwen_b,
    output logic [WIDTH-1:0]      q_a,
    output logic [WIDTH-1:0]      q_b,
    output logic                  q_valid_a,
    output logic                  q_valid_b,
    output logic                  collision
);

    // One extra bit so the range check also works when DEPTH is a power of two.
    localparam logic [ADDR_WIDTH:0] DEPTH_X = (ADDR_WIDTH + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];

    logic             ok_a, ok_b, rd_a, rd_b, wr_a, wr_b, same_addr;
    logic [WIDTH-1:0] word_a, word_b;
    logic             s1_valid_a, s1_valid_b;
    logic [WIDTH-1:0] s1_data_a, s1_data_b;

    function automatic logic [WIDTH-1:0] merge_lanes(input logic [WIDTH-1:0] old_word,
                                                     input logic [WIDTH-1:0] new_word,
                                                     input logic [NLANES-1:0] lanes);
        logic [WIDTH-1:0] res;
        res = old_word;
        for (int l = 0; l < NLANES; l++) begin
            if (lanes[l]) res[l*MASK_GRAN +: MASK_GRAN] = new_word[l*MASK_GRAN +: MASK_GRAN];
        end
        return res;
    endfunction

    assign ok_a      = {1'b0, a_a} < DEPTH_X;
    assign ok_b      = {1'b0, a_b} < DEPTH_X;
    assign rd_a      = !cen_a && rdwen_a;
    assign rd_b      = !cen_b && rdwen_b;
    assign wr_a      = !cen_a && !rdwen_a && ok_a;
    assign wr_b      = !cen_b && !rdwen_b && ok_b;
    assign same_addr = (a_a == a_b);

    always_comb begin
        word_a = '0;
        word_b = '0;
        if (ok_a) word_a = mem[a_a];
        if (ok_b) word_b = mem[a_b];
        if (BYPASS != 0 && wr_b && same_addr) word_a = merge_lanes(word_a, d_b, bwen_b);
        if (BYPASS != 0 && wr_a && same_addr) word_b = merge_lanes(word_b, d_a, bwen_a);
    end

    // Port A is written last so it wins lanes enabled on both ports.
    always_ff @(posedge clk) begin
        if (nreset) begin
            for (int l = 0; l < NLANES; l++) begin
                if (wr_b && bwen_b[l]) mem[a_b][l*MASK_GRAN +: MASK_GRAN] <= d_b[l*MASK_GRAN +: MASK_GRAN];
                if (wr_a && bwen_a[l]) mem[a_a][l*MASK_GRAN +: MASK_GRAN] <= d_a[l*MASK_GRAN +: MASK_GRAN];
            end
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            s1_valid_a <= 1'b0;
            s1_valid_b <= 1'b0;
            s1_data_a  <= '0;
            s1_data_b  <= '0;
            collision  <= 1'b0;
        end else begin
            s1_valid_a <= rd_a;
            s1_valid_b <= rd_b;
            if (rd_a) s1_data_a <= word_a;
            if (rd_b) s1_data_b <= word_b;
            collision  <= !cen_a && !cen_b && ok_a && same_addr && (!rdwen_a || !rdwen_b);
        end
    end

    generate
        if (READ_LATENCY == 2) begin : g_lat2
            logic             s2_valid_a, s2_valid_b;
            logic [WIDTH-1:0] s2_data_a, s2_data_b;

            always_ff @(posedge clk or negedge nreset) begin
                if (!nreset) begin
                    s2_valid_a <= 1'b0;
                    s2_valid_b <= 1'b0;
                    s2_data_a  <= '0;
                    s2_data_b  <= '0;
                end else begin
                    s2_valid_a <= s1_valid_a;
                    s2_valid_b <= s1_valid_b;
                    if (s1_valid_a) s2_data_a <= s1_data_a;
                    if (s1_valid_b) s2_data_b <= s1_data_b;
                end
            end

            assign q_a       = s2_data_a;
            assign q_b       = s2_data_b;
            assign q_valid_a = s2_valid_a;
            assign q_valid_b = s2_valid_b;
        end else begin : g_lat1
            assign q_a       = s1_data_a;
            assign q_b       = s1_data_b;
            assign q_valid_a = s1_valid_a;
            assign q_valid_b = s1_valid_b;
        end
    endgenerate

endmodule

// File: tb/tb_dpram_param.sv
// Drives a default build and a DEPTH=1000 / latency-2 / no-bypass build with the
// same stimulus and checks both against an array-based reference model.
module tb_dpram_param;

    logic        clk = 1'b0;
    logic        nreset = 1'b1;
    logic        cen [2];
    logic        rw  [2];
    logic [10:0] adr [2];
    logic [15:0] dat [2];
    logic [1:0]  bw  [2];

    logic [15:0] q0a, q0b, q1a, q1b;
    logic        v0a, v0b, v1a, v1b, col0, col1;

    int n_vec  = 0;
    int n_fail = 0;

    logic [15:0] mdl  [2][2048];
    logic [15:0] eq   [2][2];
    logic        ev   [2][2];
    logic [15:0] sd   [2][2];
    logic        sv   [2][2];
    logic        ecol [2];

    typedef struct {
        logic        ca, ra;
        logic [10:0] aa;
        logic [15:0] da;
        logic [1:0]  ba;
        logic        cb, rb;
        logic [10:0] ab;
        logic [15:0] db;
        logic [1:0]  bb;
        logic [15:0] qa, qb;
        logic        va, vb, col;
    } vec_t;

    vec_t tbl [19];

    always #5 clk = ~clk;

    dpram_param dut0 (
        .clk(clk), .nreset(nreset),
        .cen_a(cen[0]), .rdwen_a(rw[0]), .a_a(adr[0]), .d_a(dat[0]), .bwen_a(bw[0]),
        .cen_b(cen[1]), .rdwen_b(rw[1]), .a_b(adr[1]), .d_b(dat[1]), .bwen_b(bw[1]),
        .q_a(q0a), .q_b(q0b), .q_valid_a(v0a), .q_valid_b(v0b), .collision(col0)
    );

    dpram_param #(.DEPTH(1000), .READ_LATENCY(2), .BYPASS(0)) dut1 (
        .clk(clk), .nreset(nreset),
        .cen_a(cen[0]), .rdwen_a(rw[0]), .a_a(adr[0][9:0]), .d_a(dat[0]), .bwen_a(bw[0]),
        .cen_b(cen[1]), .rdwen_b(rw[1]), .a_b(adr[1][9:0]), .d_b(dat[1]), .bwen_b(bw[1]),
        .q_a(q1a), .q_b(q1b), .q_valid_a(v1a), .q_valid_b(v1b), .collision(col1)
    );

    function automatic vec_t mk(int ca, int ra, int aa, int da, int ba,
                                int cb, int rb, int ab, int db, int bb,
                                int qa, int qb, int va, int vb, int col);
        vec_t v;
        v.ca = 1'(ca); v.ra = 1'(ra); v.aa = 11'(aa); v.da = 16'(da); v.ba = 2'(ba);
        v.cb = 1'(cb); v.rb = 1'(rb); v.ab = 11'(ab); v.db = 16'(db); v.bb = 2'(bb);
        v.qa = 16'(qa); v.qb = 16'(qb); v.va = 1'(va); v.vb = 1'(vb); v.col = 1'(col);
        return v;
    endfunction

    function automatic logic [15:0] merge(input logic [15:0] o, input logic [15:0] n,
                                          input logic [1:0] b);
        logic [15:0] r;
        r = o;
        for (int l = 0; l < 2; l++) if (b[l]) r[l*8 +: 8] = n[l*8 +: 8];
        return r;
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input int p, input int c, input int r, input int a,
                         input int d, input int b);
        cen[p] = 1'(c); rw[p] = 1'(r); adr[p] = 11'(a); dat[p] = 16'(d); bw[p] = 2'(b);
    endtask

    task automatic model_clear();
        for (int k = 0; k < 2; k++) begin
            ecol[k] = 1'b0;
            for (int p = 0; p < 2; p++) begin
                eq[k][p] = '0; ev[k][p] = 1'b0; sd[k][p] = '0; sv[k][p] = 1'b0;
            end
        end
    endtask

    // Applies one clock edge of the currently driven requests to the model.
    task automatic model_step();
        int          a [2];
        bit          ok [2], rd [2], wr [2];
        logic [15:0] w [2];
        int          depth;
        bit          byp;
        for (int k = 0; k < 2; k++) begin
            depth = (k == 1) ? 1000 : 2048;
            byp   = (k == 0);
            for (int p = 0; p < 2; p++) begin
                a[p]  = (k == 1) ? int'(adr[p][9:0]) : int'(adr[p]);
                ok[p] = a[p] < depth;
                rd[p] = !cen[p] && rw[p];
                wr[p] = !cen[p] && !rw[p] && ok[p];
                w[p]  = ok[p] ? mdl[k][a[p]] : 16'h0;
            end
            for (int p = 0; p < 2; p++)
                if (byp && rd[p] && wr[1-p] && a[p] == a[1-p]) w[p] = merge(w[p], dat[1-p], bw[1-p]);
            ecol[k] = !cen[0] && !cen[1] && ok[0] && (a[0] == a[1]) && (wr[0] || wr[1]);
            if (wr[1]) mdl[k][a[1]] = merge(mdl[k][a[1]], dat[1], bw[1]);
            if (wr[0]) mdl[k][a[0]] = merge(mdl[k][a[0]], dat[0], bw[0]);
            for (int p = 0; p < 2; p++) begin
                if (k == 0) begin
                    ev[k][p] = rd[p];
                    if (rd[p]) eq[k][p] = w[p];
                end else begin
                    ev[k][p] = sv[k][p];
                    if (sv[k][p]) eq[k][p] = sd[k][p];
                    sv[k][p] = rd[p];
                    if (rd[p]) sd[k][p] = w[p];
                end
            end
        end
    endtask

    task automatic check_model();
        check("d0_q_a", q0a, eq[0][0]);         check("d0_q_b", q0b, eq[0][1]);
        check("d0_qv_a", 16'(v0a), 16'(ev[0][0])); check("d0_qv_b", 16'(v0b), 16'(ev[0][1]));
        check("d0_coll", 16'(col0), 16'(ecol[0]));
        check("d1_q_a", q1a, eq[1][0]);         check("d1_q_b", q1b, eq[1][1]);
        check("d1_qv_a", 16'(v1a), 16'(ev[1][0])); check("d1_qv_b", 16'(v1b), 16'(ev[1][1]));
        check("d1_coll", 16'(col1), 16'(ecol[1]));
    endtask

    // Inputs are already driven; take one edge and compare 1 time unit later.
    task automatic step();
        @(posedge clk);
        if (nreset) model_step();
        #1;
        check_model();
    endtask

    task automatic idle_both();
        drive(0, 1, 1, 0, 0, 0);
        drive(1, 1, 1, 0, 0, 0);
    endtask

    task automatic reset_now();
        @(negedge clk);
        nreset = 1'b0;
        model_clear();
        #1;
        check_model();
    endtask

    function automatic int pick_addr();
        case ($urandom_range(0, 3))
            0:       return int'($urandom_range(0, 7));
            1:       return int'($urandom_range(995, 1030));
            2:       return int'($urandom_range(1020, 1027));
            default: return int'($urandom_range(0, 2047));
        endcase
    endfunction

    initial begin
        tbl[0]  = mk(0,0,5,'hBEEF,3,   1,1,0,0,0,         'h0,'h0,0,0,0);
        tbl[1]  = mk(1,1,0,0,0,        0,1,5,0,0,         'h0,'hBEEF,0,1,0);
        tbl[2]  = mk(0,0,9,'h1234,3,   1,1,0,0,0,         'h0,'hBEEF,0,0,0);
        tbl[3]  = mk(0,0,9,'hABCD,1,   1,1,0,0,0,         'h0,'hBEEF,0,0,0);
        tbl[4]  = mk(0,1,9,0,0,        1,1,0,0,0,         'h12CD,'hBEEF,1,0,0);
        tbl[5]  = mk(0,0,9,'h1234,3,   1,1,0,0,0,         'h12CD,'hBEEF,0,0,0);
        tbl[6]  = mk(0,0,9,'hABCD,0,   1,1,0,0,0,         'h12CD,'hBEEF,0,0,0);
        tbl[7]  = mk(1,1,0,0,0,        0,1,9,0,0,         'h12CD,'h1234,0,1,0);
        tbl[8]  = mk(0,0,3,'h1111,3,   0,0,3,'h2222,3,    'h12CD,'h1234,0,0,1);
        tbl[9]  = mk(0,1,3,0,0,        1,1,0,0,0,         'h1111,'h1234,1,0,0);
        tbl[10] = mk(0,0,3,'h1111,2,   0,0,3,'h2222,1,    'h1111,'h1234,0,0,1);
        tbl[11] = mk(1,1,0,0,0,        0,1,3,0,0,         'h1111,'h1122,0,1,0);
        tbl[12] = mk(0,0,7,'h0F0F,3,   1,1,0,0,0,         'h1111,'h1122,0,0,0);
        tbl[13] = mk(0,0,7,'hF0F0,3,   0,1,7,0,0,         'h1111,'hF0F0,0,1,1);
        tbl[14] = mk(0,1,7,0,0,        0,1,7,0,0,         'hF0F0,'hF0F0,1,1,0);
        tbl[15] = mk(0,1,5,0,0,        0,0,5,'h0011,1,    'hBE11,'hF0F0,1,0,1);
        tbl[16] = mk(0,0,20,'hAAAA,3,  0,0,21,'h5555,3,   'hBE11,'hF0F0,0,0,0);
        tbl[17] = mk(0,0,1010,'h5A5A,3, 0,1,1010,0,0,     'hBE11,'h5A5A,0,1,1);
        tbl[18] = mk(1,1,0,0,0,        0,1,1010,0,0,      'hBE11,'h5A5A,0,1,0);

        idle_both();
        model_clear();
        #2 nreset = 1'b0;
        #1 check_model();
        @(posedge clk);
        @(posedge clk);
        #1 nreset = 1'b1;

        // Fill every word so later reads never see uninitialised contents.
        for (int i = 0; i < 1024; i++) begin
            drive(0, 0, 0, 2*i,     int'($urandom()), 3);
            drive(1, 0, 0, 2*i + 1, int'($urandom()), 3);
            step();
        end
        idle_both();
        step();

        // Directed table: model checks both builds, table pins the default build.
        for (int i = 0; i < 19; i++) begin
            drive(0, tbl[i].ca, tbl[i].ra, tbl[i].aa, tbl[i].da, tbl[i].ba);
            drive(1, tbl[i].cb, tbl[i].rb, tbl[i].ab, tbl[i].db, tbl[i].bb);
            step();
            check($sformatf("tbl%0d_q_a", i), q0a, tbl[i].qa);
            check($sformatf("tbl%0d_q_b", i), q0b, tbl[i].qb);
            check($sformatf("tbl%0d_qv_a", i), 16'(v0a), 16'(tbl[i].va));
            check($sformatf("tbl%0d_qv_b", i), 16'(v0b), 16'(tbl[i].vb));
            check($sformatf("tbl%0d_coll", i), 16'(col0), 16'(tbl[i].col));
        end
        idle_both();
        step();
        step();

        // Streaming reads on both ports, then reset in the middle of the stream.
        for (int i = 0; i < 16; i++) begin
            drive(0, 0, 1, i, 0, 0);
            drive(1, 0, 1, i, 0, 0);
            step();
            if (i >= 1) begin
                check("stream_d1_qv_a", 16'(v1a), 16'h1);
                check("stream_d1_qv_b", 16'(v1b), 16'h1);
            end
        end
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 1, 40 + i, 0, 0);
            drive(1, 0, 1, 41 + i, 0, 0);
            step();
        end
        reset_now();
        drive(0, 0, 0, 5, 'hDEAD, 3);
        drive(1, 0, 1, 6, 0, 0);
        step();
        nreset = 1'b1;
        idle_both();
        for (int i = 0; i < 3; i++) step();
        drive(0, 0, 1, 5, 0, 0);
        step();
        idle_both();
        step();
        step();

        // Random traffic concentrated on a few hot and out-of-range addresses.
        for (int i = 0; i < 3000; i++) begin
            for (int p = 0; p < 2; p++)
                drive(p, ($urandom_range(0, 3) == 0) ? 1 : 0, int'($urandom_range(0, 1)),
                      pick_addr(), int'($urandom()), int'($urandom_range(0, 3)));
            step();
            if (i == 1500) begin
                reset_now();
                step();
                nreset = 1'b1;
            end
        end
        idle_both();
        step();
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
